// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port BRAM and its stream read sequencer.
package bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/bram_skid_fifo.sv
// Two-entry synchronous FIFO; absorbs the in-flight BRAM read while the consumer stalls.
module bram_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    // Push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/bram_stream_reader.sv
// Reads LENGTH consecutive BRAM words from BASE_ADDR (modulo depth) and streams them out
// with m_last on the final word; hides the BRAM's one-cycle read latency and backpressure.
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [RAM_ADDR_WIDTH:0]   length,
    output logic                      busy,
    output logic                      done,
    output logic                      ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_data_in,
    input  logic [RAM_DATA_WIDTH-1:0] ram_data_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [RAM_DATA_WIDTH-1:0] m_data,
    output logic                      m_last,
    output state_e                    dbg_state,
    output logic [1:0]                dbg_fifo_cnt,
    output logic                      dbg_fifo_full
);

    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DW = RAM_DATA_WIDTH;

    state_e      state;
    logic [AW:0] length_r;
    logic [AW:0] issue_cnt;
    logic [AW:0] beat_cnt;
    logic        rd_pending;
    logic        issue;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [1:0]  fifo_cnt;

    // Stream handshake: a word transfers on a cycle where m_valid && m_ready; while
    // m_valid is high and m_ready low, m_data and m_last stay unchanged.
    assign pop     = m_valid & m_ready;
    assign m_valid = ~fifo_empty;
    assign m_last  = m_valid & (beat_cnt == length_r - 1'b1);

    // Credit: words held plus the read in flight, after this cycle's pop, must leave a free slot.
    assign issue = (state == RUN) && (issue_cnt < length_r) &&
                   (({1'b0, fifo_cnt} + {2'b00, rd_pending}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_addr   <= '0;
            length_r   <= '0;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        length_r  <= length;
                        ram_addr  <= base_addr;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_pending <= 1'b1;
                        issue_cnt  <= issue_cnt + 1'b1;
                        ram_addr   <= ram_addr + 1'b1;
                    end
                    if (pop) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (m_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    bram_skid_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pending),
        .pop   (pop),
        .din   (ram_data_out),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

    assign ram_wr        = 1'b0;
    assign ram_data_in   = '0;
    assign dbg_state     = state;
    assign dbg_fifo_cnt  = fifo_cnt;
    assign dbg_fifo_full = fifo_full;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural one-cycle-latency BRAM.
module tb_bram_stream_reader;
    import bram_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic       ram_wr;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    state_e     dbg_state;
    logic [1:0] dbg_fifo_cnt;
    logic       dbg_fifo_full;

    logic [7:0] mem [16];
    logic       pat [6];
    int         n_checks;
    int         n_pass;

    bram_stream_reader #(.RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .ram_wr        (ram_wr),
        .ram_addr      (ram_addr),
        .ram_data_in   (ram_data_in),
        .ram_data_out  (ram_data_out),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .dbg_state     (dbg_state),
        .dbg_fifo_cnt  (dbg_fifo_cnt),
        .dbg_fifo_full (dbg_fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM read port: registered read, data valid one cycle after the address.
    always @(posedge clk) ram_data_out <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and consumes its stream. mode 0: m_ready held 1; mode 1: ready pattern.
    // poke_at >= 0 re-pulses start with a different command at that stream cycle.
    task automatic run_stream(input int base, input int len, input int mode, input int poke_at);
        int         n;
        int         first;
        logic       stalled;
        logic [7:0] held_d;
        logic       held_l;
        logic [7:0] exp_d;
        base_addr = 4'(base);
        length    = 5'(len);
        start     = 1'b1;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        if (len == 0) begin
            check("len0_done", 32'(done), 32'd1);
            check("len0_busy", 32'(busy), 32'd0);
            check("len0_valid", 32'(m_valid), 32'd0);
            tick();
            check("len0_done_pulse", 32'(done), 32'd0);
            check("len0_valid_after", 32'(m_valid), 32'd0);
            check("len0_idle", 32'(dbg_state), 32'(IDLE));
            return;
        end
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_addr", 32'(ram_addr), 32'(base % 16));
        n       = 0;
        first   = -1;
        stalled = 1'b0;
        held_d  = 8'h00;
        held_l  = 1'b0;
        for (int c = 0; c < 300 && n < len; c++) begin
            if (c == poke_at) begin
                start     = 1'b1;
                base_addr = 4'(base + 5);
                length    = 5'd2;
            end else begin
                start = 1'b0;
            end
            m_ready = (mode == 0) ? 1'b1 : pat[c % 6];
            if (m_valid && first < 0) first = c;
            if (stalled) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(held_d));
                check("hold_last", 32'(m_last), 32'(held_l));
            end
            check("fifo_cnt_le2", 32'(dbg_fifo_cnt <= 2'd2), 32'd1);
            check("busy_run", 32'(busy), 32'd1);
            check("no_early_done", 32'(done), 32'd0);
            check("ram_wr_zero", 32'(ram_wr), 32'd0);
            if (m_valid && m_ready) begin
                exp_d = 8'h10 + 8'((base + n) % 16);
                check("data", 32'(m_data), 32'(exp_d));
                check("last", 32'(m_last), 32'(n == len - 1));
                if (mode == 0 && poke_at < 0) check("cadence", 32'(c), 32'(2 + n));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = m_valid;
                held_d  = m_data;
                held_l  = m_last;
            end
            tick();
        end
        start = 1'b0;
        check("word_count", 32'(n), 32'(len));
        if (mode == 0 && poke_at < 0) check("first_valid_cycle", 32'(first), 32'd2);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        check("valid_after_last", 32'(m_valid), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("back_idle", 32'(dbg_state), 32'(IDLE));
        check("no_extra_word", 32'(m_valid), 32'd0);
    endtask

    initial begin
        int hs;
        n_checks  = 0;
        n_pass    = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i) + 8'h10;
        pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        rst       = 1'b0;
        start     = 1'b0;
        base_addr = 4'd0;
        length    = 5'd0;
        m_ready   = 1'b0;

        tick();
        tick();
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_din", 32'(ram_data_in), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b1;
        tick();

        run_stream(2, 4, 0, -1);    // 12,13,14,15
        run_stream(14, 4, 0, -1);   // wraps 1e,1f,10,11
        run_stream(5, 5, 1, -1);    // backpressure
        run_stream(0, 0, 0, -1);    // empty command
        run_stream(3, 16, 0, 4);    // start re-pulsed mid-stream

        // Reset after two of six words.
        base_addr = 4'd0;
        length    = 5'd6;
        start     = 1'b1;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        hs    = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            if (m_valid && m_ready) hs++;
            tick();
        end
        check("pre_reset_words", 32'(hs), 32'd2);
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        check("abort_last", 32'(m_last), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_valid", 32'(m_valid), 32'd0);
        end
        run_stream(7, 3, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
